// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant held until the slave terminates,
// the granted master drops cyc, or the bus watchdog expires.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_BUSY   = 1'b1;
  localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYCLES[15:0];
  localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

  logic [0:0]  r_state;
  logic [1:0]  r_grant;
  logic        r_last;
  logic [15:0] r_cnt;

  logic w_busy;
  logic w_req0;
  logic w_req1;
  logic w_sel1;
  logic w_gcyc;
  logic w_gstb;
  logic w_term;
  logic w_tmo;
  logic w_win1;

  assign w_busy = (r_state == ST_BUSY);
  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_sel1 = r_grant[1];
  assign w_gcyc = w_sel1 ? m1_cyc_i : m0_cyc_i;
  assign w_gstb = w_sel1 ? m1_stb_i : m0_stb_i;
  assign w_term = w_busy & (wb_ack_i | wb_err_i | wb_rty_i);

  // A slave termination in the expiry cycle takes precedence over the watchdog.
  assign w_tmo  = TMO_EN && w_busy && !w_term && (r_cnt == TMO_LIMIT);

  // On a tie the master that was not served last wins.
  assign w_win1 = w_req1 & (~w_req0 | ~r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else if (!w_busy) begin
      if (w_req0 | w_req1) begin
        r_state <= ST_BUSY;
        r_grant <= w_win1 ? 2'b10 : 2'b01;
        r_cnt   <= '0;
      end
    end else begin
      if (w_term | w_tmo) begin
        r_state <= ST_IDLE;
        r_grant <= 2'b00;
        r_last  <= w_sel1;
      end else if (!w_gcyc) begin
        r_state <= ST_IDLE;
        r_grant <= 2'b00;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt   <= r_cnt + 16'd1;
      end
    end
  end

  // Slave-side request is a pure mux of the owner; forced idle outside BUSY.
  assign wb_adr_o  = w_busy ? (w_sel1 ? m1_adr_i : m0_adr_i) : 32'd0;
  assign wb_dat_o  = w_busy ? (w_sel1 ? m1_dat_i : m0_dat_i) : 32'd0;
  assign wb_we_o   = w_busy & (w_sel1 ? m1_we_i : m0_we_i);
  assign wb_sel_o  = w_busy ? (w_sel1 ? m1_sel_i : m0_sel_i) : 4'd0;
  assign wb_cyc_o  = w_busy & w_gcyc & w_gstb & ~w_tmo;
  assign wb_stb_o  = w_busy & w_gcyc & w_gstb & ~w_tmo;

  assign m0_ack_o  = r_grant[0] & wb_ack_i;
  assign m0_err_o  = r_grant[0] & (wb_err_i | w_tmo);
  assign m0_rty_o  = r_grant[0] & wb_rty_i;
  assign m1_ack_o  = r_grant[1] & wb_ack_i;
  assign m1_err_o  = r_grant[1] & (wb_err_i | w_tmo);
  assign m1_rty_o  = r_grant[1] & wb_rty_i;

  assign m0_dat_o  = wb_dat_i;
  assign m1_dat_o  = wb_dat_i;
  assign grant_o   = r_grant;
  assign timeout_o = w_tmo;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_wb_arbiter2;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_we, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_stb, m0_cyc, m1_stb, m1_cyc;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: owning master (-1 = bus free), last master served,
  // and number of BUSY cycles already spent in the current transaction.
  int md_owner;
  int md_last;
  int md_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_owner = -1;
    md_last  = 1;
    md_age   = 0;
  endtask

  // Compare every output with the model for the current cycle, then step the model.
  task automatic model_check();
    logic [31:0] e_adr, e_dat;
    logic        e_we, e_req, e_tmo, term, r0, r1, own_cyc;
    logic [3:0]  e_sel;
    logic [2:0]  e_t0, e_t1;
    logic [1:0]  e_gnt;
    e_adr = '0; e_dat = '0; e_we = 1'b0; e_sel = '0; e_req = 1'b0;
    e_t0 = '0; e_t1 = '0; e_gnt = '0; e_tmo = 1'b0; own_cyc = 1'b0;
    r0   = m0_cyc & m0_stb;
    r1   = m1_cyc & m1_stb;
    term = wb_ack_i | wb_err_i | wb_rty_i;
    if (md_owner >= 0) begin
      e_tmo = (md_age == T) && !term;
      if (md_owner == 0) begin
        e_gnt = 2'b01; e_adr = m0_adr; e_dat = m0_dat; e_we = m0_we; e_sel = m0_sel;
        e_req = m0_cyc & m0_stb; own_cyc = m0_cyc;
        e_t0  = {wb_ack_i, wb_err_i | e_tmo, wb_rty_i};
      end else begin
        e_gnt = 2'b10; e_adr = m1_adr; e_dat = m1_dat; e_we = m1_we; e_sel = m1_sel;
        e_req = m1_cyc & m1_stb; own_cyc = m1_cyc;
        e_t1  = {wb_ack_i, wb_err_i | e_tmo, wb_rty_i};
      end
    end
    chk("wb_adr", wb_adr_o, e_adr);
    chk("wb_dat", wb_dat_o, e_dat);
    chk("wb_we_sel_stb", {26'd0, wb_we_o, wb_sel_o, wb_stb_o}, {26'd0, e_we, e_sel, e_req & ~e_tmo});
    chk("wb_cyc", {31'd0, wb_cyc_o}, {31'd0, e_req & ~e_tmo});
    chk("m0_term", {29'd0, m0_ack_o, m0_err_o, m0_rty_o}, {29'd0, e_t0});
    chk("m1_term", {29'd0, m1_ack_o, m1_err_o, m1_rty_o}, {29'd0, e_t1});
    chk("grant", {30'd0, grant_o}, {30'd0, e_gnt});
    chk("timeout", {31'd0, timeout_o}, {31'd0, e_tmo});
    chk("m0_dat", m0_dat_o, wb_dat_i);
    chk("m1_dat", m1_dat_o, wb_dat_i);
    if (md_owner < 0) begin
      if (r0 || r1) begin
        md_owner = (r0 && r1) ? (1 - md_last) : (r0 ? 0 : 1);
        md_age   = 0;
      end
    end else if (term || e_tmo) begin
      md_last  = md_owner;
      md_owner = -1;
    end else if (!own_cyc) begin
      md_owner = -1;
    end else begin
      md_age++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    #4;
    model_check();
    advance();
  endtask

  task automatic clear_inputs();
    m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_sel = '0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_sel = '0; m1_stb = 1'b0; m1_cyc = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, {30'd0, grant_o}, 32'd0);
    chk({tag, "_wbreq"}, {25'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
    chk({tag, "_wbadr"}, wb_adr_o, 32'd0);
    chk({tag, "_term"}, {25'd0, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, timeout_o}, 32'd0);
  endtask

  initial begin
    int r;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_all_zero("reset");
    advance();
    advance();
    rst = 1'b1;

    // Single read from m1, slave answers two cycles after strobe.
    m1_adr = 32'h1000_0005; m1_sel = 4'b0001; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    #4; model_check(); chk("t1_stb_req_cycle", {31'd0, wb_stb_o}, 32'd0); advance();
    #4; model_check(); chk("t1_stb_next", {31'd0, wb_stb_o}, 32'd1);
    chk("t1_grant", {30'd0, grant_o}, 32'd2); advance();
    run_cycle();
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0041;
    #4; model_check(); chk("t1_ack", {31'd0, m1_ack_o}, 32'd1);
    chk("t1_dat", m1_dat_o, 32'h41); advance();
    clear_inputs();
    #4; model_check(); chk("t1_grant_idle", {30'd0, grant_o}, 32'd0); advance();

    // Both masters request continuously with a zero-wait slave.
    m0_adr = 32'h0000_0100; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h2000_0000; m1_sel = 4'hF; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb_ack_i = i[0];
      #4; model_check();
      if (i % 2 == 1) begin
        chk("t2_order", {30'd0, grant_o}, ((i % 4) == 1) ? 32'd1 : 32'd2);
        chk("t2_ack", {30'd0, m1_ack_o, m0_ack_o}, ((i % 4) == 1) ? 32'd1 : 32'd2);
      end
      advance();
    end
    clear_inputs();
    run_cycle();

    // m1 write queued behind an in-flight m0 read.
    m0_adr = 32'h0000_0200; m0_dat = 32'h1111_2222; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    run_cycle();
    m1_adr = 32'h8000_0010; m1_dat = 32'hDEAD_BEEF; m1_we = 1'b1; m1_sel = 4'b1100;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_ack_i = (i == 2);
      #4; model_check();
      chk("t3_wdat_held", wb_dat_o, 32'h1111_2222);
      chk("t3_we_held", {31'd0, wb_we_o}, 32'd0);
      chk("t3_m1_noack", {31'd0, m1_ack_o}, 32'd0);
      advance();
    end
    wb_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    run_cycle();
    wb_ack_i = 1'b1;
    #4; model_check();
    chk("t3_wdat", wb_dat_o, 32'hDEAD_BEEF);
    chk("t3_wadr", wb_adr_o, 32'h8000_0010);
    chk("t3_we_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, 1'b1, 4'b1100});
    advance();
    clear_inputs();
    run_cycle();

    // Watchdog: slave never answers m0 while m1 waits.
    m0_adr = 32'h0000_0300; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h0000_0400; m1_cyc = 1'b1; m1_stb = 1'b1;
    run_cycle();
    for (int i = 1; i <= 5; i++) begin
      #4; model_check();
      chk("t4_err", {31'd0, m0_err_o}, (i == 5) ? 32'd1 : 32'd0);
      chk("t4_timeout", {31'd0, timeout_o}, (i == 5) ? 32'd1 : 32'd0);
      if (i == 5) chk("t4_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
      advance();
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    run_cycle();
    wb_ack_i = 1'b1;
    #4; model_check(); chk("t4_next_grant", {30'd0, grant_o}, 32'd2); advance();
    clear_inputs();
    run_cycle();

    // Error then retry routed to m1 only.
    m1_adr = 32'h0000_0500; m1_cyc = 1'b1; m1_stb = 1'b1;
    run_cycle();
    wb_err_i = 1'b1;
    #4; model_check(); chk("t5_err", {31'd0, m1_err_o}, 32'd1);
    chk("t5_m0_quiet_err", {29'd0, m0_ack_o, m0_err_o, m0_rty_o}, 32'd0); advance();
    wb_err_i = 1'b0;
    run_cycle();
    wb_rty_i = 1'b1;
    #4; model_check(); chk("t5_rty", {31'd0, m1_rty_o}, 32'd1);
    chk("t5_m0_quiet_rty", {29'd0, m0_ack_o, m0_err_o, m0_rty_o}, 32'd0); advance();
    wb_rty_i = 1'b0; m0_adr = 32'h0000_0600; m0_cyc = 1'b1; m0_stb = 1'b1;
    run_cycle();
    wb_ack_i = 1'b1;
    #4; model_check(); chk("t5_tie_after_rty", {30'd0, grant_o}, 32'd1); advance();
    clear_inputs();
    run_cycle();

    // Master abort, then asynchronous reset in the middle of an m1 transfer.
    m0_adr = 32'h0000_0700; m0_cyc = 1'b1; m0_stb = 1'b1;
    run_cycle();
    run_cycle();
    m0_cyc = 1'b0;
    #4; model_check(); chk("t6_abort_cyc", {31'd0, wb_cyc_o}, 32'd0); advance();
    m0_stb = 1'b0; m1_adr = 32'h0000_0800; m1_cyc = 1'b1; m1_stb = 1'b1;
    run_cycle();
    run_cycle();
    chk("t6_busy_before_rst", {30'd0, grant_o}, 32'd2);
    wb_ack_i = 1'b1;
    rst = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    model_reset();
    advance();
    rst = 1'b1; wb_ack_i = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    run_cycle();
    wb_ack_i = 1'b1;
    #4; model_check(); chk("t6_tie_after_reset", {30'd0, grant_o}, 32'd1); advance();
    clear_inputs();
    run_cycle();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      m0_cyc = ($urandom_range(0, 7) != 0);
      m0_stb = ($urandom_range(0, 3) != 0);
      m1_cyc = ($urandom_range(0, 7) != 0);
      m1_stb = ($urandom_range(0, 3) != 0);
      m0_adr = $urandom; m0_dat = $urandom; m0_we = 1'($urandom_range(0, 1));
      m0_sel = 4'($urandom_range(0, 15));
      m1_adr = $urandom; m1_dat = $urandom; m1_we = 1'($urandom_range(0, 1));
      m1_sel = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      wb_ack_i = (r < 2);
      wb_err_i = (r == 2);
      wb_rty_i = (r == 3);
      wb_dat_i = $urandom;
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
